// File: rtl/sata_reg_bank.sv
// sata_reg_bank: SATA host control/status registers, command slots, interrupt status,
// error counter and scratch RAM behind a byte-masked write port and a two-stage read port.
module sata_reg_bank #(
    parameter int          CMD_SLOTS    = 8,
    parameter int          SCRATCH_BITS = 4,
    parameter logic [31:0] VERSION      = 32'h0001_0000
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic [15:0]          bram_waddr,
    input  logic [31:0]          bram_wdata,
    input  logic [3:0]           bram_wstb,
    input  logic                 bram_wen,
    input  logic [15:0]          bram_raddr,
    input  logic                 bram_ren,
    input  logic                 bram_regen,
    output logic [31:0]          bram_rdata,
    output logic [31:0]          ctrl,
    output logic [CMD_SLOTS-1:0] cmd_issue,
    input  logic [CMD_SLOTS-1:0] cmd_done,
    input  logic [7:0]           int_events,
    output logic                 irq,
    input  logic                 err_pulse,
    input  logic [31:0]          hw_status
);
    localparam int DEPTH = 1 << SCRATCH_BITS;

    logic [31:0]          m;
    logic [15:0]          woff, roff;
    logic                 w_scr, r_scr;
    logic                 wr_ctrl, wr_cmd, wr_int, wr_mask, wr_err;
    logic [7:0]           int_status, int_mask;
    logic [15:0]          err_count;
    logic [31:0]          scratch [DEPTH];
    logic [31:0]          rval, stage1;
    logic [CMD_SLOTS-1:0] cmd_set;
    logic [7:0]           int_clr;

    assign m       = {{8{bram_wstb[3]}}, {8{bram_wstb[2]}}, {8{bram_wstb[1]}}, {8{bram_wstb[0]}}};
    // Offsets below the scratch base wrap to large values and fall out of range.
    assign woff    = bram_waddr - 16'h0100;
    assign roff    = bram_raddr - 16'h0100;
    assign w_scr   = bram_wen && ({1'b0, woff} < 17'(DEPTH));
    assign r_scr   = {1'b0, roff} < 17'(DEPTH);
    assign wr_ctrl = bram_wen && bram_waddr == 16'h0000;
    assign wr_cmd  = bram_wen && bram_waddr == 16'h0001;
    assign wr_int  = bram_wen && bram_waddr == 16'h0002;
    assign wr_mask = bram_wen && bram_waddr == 16'h0003;
    assign wr_err  = bram_wen && bram_waddr == 16'h0004 && |bram_wstb;
    assign cmd_set = wr_cmd ? bram_wdata[CMD_SLOTS-1:0] & m[CMD_SLOTS-1:0] : '0;
    assign int_clr = wr_int ? bram_wdata[7:0] & m[7:0] : 8'h00;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl       <= '0;
            cmd_issue  <= '0;
            int_status <= '0;
            int_mask   <= '0;
            err_count  <= '0;
            irq        <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl <= (ctrl & ~m) | (bram_wdata & m);
            if (wr_mask) int_mask <= (int_mask & ~m[7:0]) | (bram_wdata[7:0] & m[7:0]);
            cmd_issue  <= (cmd_issue & ~cmd_done) | cmd_set;
            int_status <= (int_status & ~int_clr) | int_events;
            err_count  <= wr_err ? {15'd0, err_pulse} :
                          (err_pulse && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
            irq        <= |(int_status & int_mask);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < DEPTH; i++) scratch[i] <= '0;
        end else if (w_scr) begin
            scratch[woff[SCRATCH_BITS-1:0]] <= (scratch[woff[SCRATCH_BITS-1:0]] & ~m) | (bram_wdata & m);
        end
    end

    always_comb begin
        rval = '0;
        if (r_scr) begin
            rval = scratch[roff[SCRATCH_BITS-1:0]];
        end else begin
            case (bram_raddr)
                16'h0000: rval = ctrl;
                16'h0001: rval = 32'(cmd_issue);
                16'h0002: rval = {24'd0, int_status};
                16'h0003: rval = {24'd0, int_mask};
                16'h0004: rval = {16'd0, err_count};
                16'h0005: rval = VERSION;
                16'h0006: rval = hw_status;
                default:  rval = '0;
            endcase
        end
    end

    // Stage 1 captures pre-edge register contents, so same-edge writes are not seen.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            stage1     <= '0;
            bram_rdata <= '0;
        end else begin
            if (bram_ren) stage1 <= rval;
            if (bram_regen) bram_rdata <= stage1;
        end
    end
endmodule

// File: tb/tb_sata_reg_bank.sv
// tb_sata_reg_bank: table-driven register access vectors plus directed multi-cycle sequences.
module tb_sata_reg_bank;
    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [15:0] bram_waddr = '0;
    logic [31:0] bram_wdata = '0;
    logic [3:0]  bram_wstb = '0;
    logic        bram_wen = 1'b0;
    logic [15:0] bram_raddr = '0;
    logic        bram_ren = 1'b0;
    logic        bram_regen = 1'b0;
    logic [31:0] bram_rdata;
    logic [31:0] ctrl;
    logic [7:0]  cmd_issue;
    logic [7:0]  cmd_done = '0;
    logic [7:0]  int_events = '0;
    logic        irq;
    logic        err_pulse = 1'b0;
    logic [31:0] hw_status = 32'hDEAD_BEEF;

    int passed = 0;
    int total = 0;

    typedef struct {
        logic [15:0] addr;
        logic        do_wr;
        logic [31:0] wdata;
        logic [3:0]  wstb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [16];

    sata_reg_bank dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .bram_waddr(bram_waddr), .bram_wdata(bram_wdata), .bram_wstb(bram_wstb), .bram_wen(bram_wen),
        .bram_raddr(bram_raddr), .bram_ren(bram_ren), .bram_regen(bram_regen), .bram_rdata(bram_rdata),
        .ctrl(ctrl), .cmd_issue(cmd_issue), .cmd_done(cmd_done),
        .int_events(int_events), .irq(irq), .err_pulse(err_pulse), .hw_status(hw_status)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        bram_waddr = a;
        bram_wdata = d;
        bram_wstb  = s;
        bram_wen   = 1'b1;
        tick();
        bram_wen   = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        bram_raddr = a;
        bram_ren   = 1'b1;
        tick();
        bram_ren   = 1'b0;
        bram_regen = 1'b1;
        tick();
        bram_regen = 1'b0;
        d = bram_rdata;
    endtask

    initial begin
        logic [31:0] d;
        vecs[0]  = '{16'h0000, 1'b0, 32'h0,         4'h0, 32'h0};
        vecs[1]  = '{16'h0001, 1'b0, 32'h0,         4'h0, 32'h0};
        vecs[2]  = '{16'h0002, 1'b0, 32'h0,         4'h0, 32'h0};
        vecs[3]  = '{16'h0003, 1'b0, 32'h0,         4'h0, 32'h0};
        vecs[4]  = '{16'h0004, 1'b0, 32'h0,         4'h0, 32'h0};
        vecs[5]  = '{16'h0005, 1'b0, 32'h0,         4'h0, 32'h0001_0000};
        vecs[6]  = '{16'h0006, 1'b0, 32'h0,         4'h0, 32'hDEAD_BEEF};
        vecs[7]  = '{16'h0100, 1'b0, 32'h0,         4'h0, 32'h0};
        vecs[8]  = '{16'h010F, 1'b0, 32'h0,         4'h0, 32'h0};
        vecs[9]  = '{16'h0007, 1'b0, 32'h0,         4'h0, 32'h0};
        vecs[10] = '{16'h0110, 1'b0, 32'h0,         4'h0, 32'h0};
        vecs[11] = '{16'h0000, 1'b1, 32'hAABBCCDD,  4'h5, 32'h00BB_00DD};
        vecs[12] = '{16'h0007, 1'b1, 32'hFFFFFFFF,  4'hF, 32'h0};
        vecs[13] = '{16'h0003, 1'b1, 32'h0000_1234, 4'h3, 32'h0000_0034};
        vecs[14] = '{16'h0005, 1'b1, 32'h0,         4'hF, 32'h0001_0000};
        vecs[15] = '{16'h0000, 1'b1, 32'h11223344,  4'h8, 32'h11BB_00DD};

        repeat (3) tick();
        check("rst_ctrl", ctrl, 32'h0);
        check("rst_cmd", {24'd0, cmd_issue}, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        check("rst_rdata", bram_rdata, 32'h0);
        ARESETN = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].do_wr) begin
                wr(vecs[i].addr, vecs[i].wdata, vecs[i].wstb);
                if (vecs[i].addr == 16'h0000) check($sformatf("ctrl_out%0d", i), ctrl, vecs[i].exp);
            end
            rd(vecs[i].addr, d);
            check($sformatf("vec%0d_a%h", i, vecs[i].addr), d, vecs[i].exp);
        end

        // read data holds until the next regen even while new reads are issued
        rd(16'h0005, d);
        bram_raddr = 16'h0000;
        bram_ren   = 1'b1;
        tick();
        tick();
        bram_ren   = 1'b0;
        check("rdata_hold", bram_rdata, 32'h0001_0000);
        hw_status = 32'h1234_5678;
        rd(16'h0006, d);
        check("hw_status_live", d, 32'h1234_5678);

        wr(16'h0001, 32'h5, 4'hF);
        check("cmd_set", {24'd0, cmd_issue}, 32'h5);
        cmd_done = 8'h01;
        tick();
        cmd_done = 8'h00;
        check("cmd_done", {24'd0, cmd_issue}, 32'h4);
        cmd_done = 8'h01;
        wr(16'h0001, 32'h1, 4'hF);
        cmd_done = 8'h00;
        check("cmd_set_wins", {24'd0, cmd_issue}, 32'h5);
        wr(16'h0001, 32'h0, 4'hF);
        check("cmd_wr0_keeps", {24'd0, cmd_issue}, 32'h5);
        wr(16'h0001, 32'h80, 4'hE);
        check("cmd_stb_masked", {24'd0, cmd_issue}, 32'h5);
        rd(16'h0001, d);
        check("cmd_read", d, 32'h5);

        wr(16'h0003, 32'h2, 4'h1);
        int_events = 8'h01;
        tick();
        int_events = 8'h00;
        tick();
        check("irq_unmasked", {31'd0, irq}, 32'h0);
        int_events = 8'h02;
        tick();
        int_events = 8'h00;
        check("irq_lag", {31'd0, irq}, 32'h0);
        tick();
        check("irq_set", {31'd0, irq}, 32'h1);
        int_events = 8'h02;
        wr(16'h0002, 32'h2, 4'hF);
        int_events = 8'h00;
        rd(16'h0002, d);
        check("w1c_event_wins", d, 32'h3);
        wr(16'h0002, 32'h3, 4'hF);
        check("irq_after_w1c", {31'd0, irq}, 32'h1);
        tick();
        check("irq_clear", {31'd0, irq}, 32'h0);
        rd(16'h0002, d);
        check("int_status_clr", d, 32'h0);

        err_pulse = 1'b1;
        repeat (3) tick();
        err_pulse = 1'b0;
        rd(16'h0004, d);
        check("err_count3", d, 32'h3);
        err_pulse = 1'b1;
        repeat (70000) tick();
        err_pulse = 1'b0;
        rd(16'h0004, d);
        check("err_sat", d, 32'hFFFF);
        err_pulse = 1'b1;
        wr(16'h0004, 32'h0, 4'h1);
        err_pulse = 1'b0;
        rd(16'h0004, d);
        check("err_clr_pulse", d, 32'h1);
        wr(16'h0004, 32'h0, 4'h0);
        rd(16'h0004, d);
        check("err_nostb", d, 32'h1);
        wr(16'h0004, 32'h0, 4'h2);
        rd(16'h0004, d);
        check("err_clr", d, 32'h0);

        for (int i = 0; i < 16; i++) wr(16'h0100 + 16'(i), 32'h0100 + 32'(i), 4'hF);
        for (int c = 0; c <= 16; c++) begin
            bram_raddr = 16'h0100 + 16'(c);
            bram_ren   = (c < 16);
            bram_regen = (c > 0);
            tick();
            if (c > 0) check($sformatf("b2b%0d", c - 1), bram_rdata, 32'h0100 + 32'(c - 1));
        end
        bram_ren   = 1'b0;
        bram_regen = 1'b0;

        bram_raddr = 16'h0103;
        bram_ren   = 1'b1;
        bram_waddr = 16'h0103;
        bram_wdata = 32'hCAFE_0000;
        bram_wstb  = 4'hF;
        bram_wen   = 1'b1;
        tick();
        bram_ren   = 1'b0;
        bram_wen   = 1'b0;
        bram_regen = 1'b1;
        tick();
        bram_regen = 1'b0;
        check("rbw_old", bram_rdata, 32'h0000_0103);
        rd(16'h0103, d);
        check("rbw_new", d, 32'hCAFE_0000);

        bram_raddr = 16'h0103;
        bram_ren   = 1'b1;
        tick();
        bram_ren   = 1'b0;
        #2;
        ARESETN = 1'b0;
        #1;
        check("rst_async_rdata", bram_rdata, 32'h0);
        check("rst_async_ctrl", ctrl, 32'h0);
        check("rst_async_cmd", {24'd0, cmd_issue}, 32'h0);
        #1;
        ARESETN = 1'b1;
        bram_regen = 1'b1;
        tick();
        bram_regen = 1'b0;
        check("rst_inflight", bram_rdata, 32'h0);
        tick();
        check("rst_inflight_hold", bram_rdata, 32'h0);
        rd(16'h0103, d);
        check("rst_scratch", d, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
